// File: rtl/sub_pipe.sv
// Carry-pipelined subtractor: X - Y split into SLICES slices, one slice per stage,
// with input skew and output deskew so a new pair can enter every enabled cycle.
module sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int SLICES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] D,
    output logic             BORROW,
    output logic             OVF,
    output logic             out_valid
);
    localparam int S = WIDTH / SLICES;

    logic [SLICES-1:0] valid_reg;
    // carry_w[k] is the carry into slice k; slice 0 gets the +1 of the two's complement
    logic carry_w [SLICES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
        end else if (en) begin
            valid_reg[0] <= in_valid;
            for (int i = 1; i < SLICES; i++) begin
                valid_reg[i] <= valid_reg[i-1];
            end
        end
    end

    assign out_valid = valid_reg[SLICES-1];

    genvar gi;
    generate
        for (gi = 0; gi < SLICES; gi++) begin : g_slice
            logic [S-1:0] x_op;
            logic [S-1:0] yn_op;
            logic [S:0]   sum_full;
            logic [S-1:0] sum_sr [SLICES-gi];

            if (gi == 0) begin : g_head
                assign x_op       = X[S-1:0];
                assign yn_op      = ~Y[S-1:0];
                assign carry_w[0] = 1'b1;
            end else begin : g_skew
                // slice gi operands wait gi cycles for the carry from below
                logic [S-1:0] x_sr  [gi];
                logic [S-1:0] yn_sr [gi];

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        for (int j = 0; j < gi; j++) begin
                            x_sr[j]  <= '0;
                            yn_sr[j] <= '0;
                        end
                    end else if (en) begin
                        x_sr[0]  <= X[gi*S +: S];
                        yn_sr[0] <= ~Y[gi*S +: S];
                        for (int j = 1; j < gi; j++) begin
                            x_sr[j]  <= x_sr[j-1];
                            yn_sr[j] <= yn_sr[j-1];
                        end
                    end
                end

                assign x_op  = x_sr[gi-1];
                assign yn_op = yn_sr[gi-1];
            end

            assign sum_full = {1'b0, x_op} + {1'b0, yn_op} + {{S{1'b0}}, carry_w[gi]};

            // sum_sr[0] is the stage register; the rest deskew it to the output stage
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int j = 0; j < SLICES - gi; j++) begin
                        sum_sr[j] <= '0;
                    end
                end else if (en) begin
                    sum_sr[0] <= sum_full[S-1:0];
                    for (int j = 1; j < SLICES - gi; j++) begin
                        sum_sr[j] <= sum_sr[j-1];
                    end
                end
            end

            assign D[gi*S +: S] = sum_sr[SLICES-gi-1];

            if (gi < SLICES - 1) begin : g_mid
                logic carry_reg;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        carry_reg <= 1'b0;
                    end else if (en) begin
                        carry_reg <= sum_full[S];
                    end
                end

                assign carry_w[gi+1] = carry_reg;
            end else begin : g_top
                logic borrow_reg;
                logic ovf_reg;

                // yn_op holds ~Y, so "signs differ" is x_msb == yn_msb
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        borrow_reg <= 1'b0;
                        ovf_reg    <= 1'b0;
                    end else if (en) begin
                        borrow_reg <= ~sum_full[S];
                        ovf_reg    <= (x_op[S-1] == yn_op[S-1]) && (sum_full[S-1] != x_op[S-1]);
                    end
                end

                assign BORROW = borrow_reg;
                assign OVF    = ovf_reg;
            end
        end
    endgenerate
endmodule

// File: tb/tb_sub_pipe.sv
// Randomized self-checking bench for sub_pipe: a latency/arithmetic reference model
// indexed by enabled clock edges, plus directed corner cases, stalls and mid-flight reset.
module tb_sub_pipe;
    localparam int WIDTH  = 32;
    localparam int SLICES = 4;
    localparam int DEPTH  = 1024;

    logic             clk;
    logic             reset;
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] D;
    logic             BORROW;
    logic             OVF;
    logic             out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: one entry per enabled edge since the last reset
    int               edge_cnt;
    logic             acc_q  [DEPTH];
    logic [WIDTH-1:0] x_q    [DEPTH];
    logic [WIDTH-1:0] y_q    [DEPTH];
    logic [WIDTH+1:0] exp_q  [DEPTH];

    sub_pipe #(.WIDTH(WIDTH), .SLICES(SLICES)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .X         (X),
        .Y         (Y),
        .D         (D),
        .BORROW    (BORROW),
        .OVF       (OVF),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // reference: {BORROW, OVF, D} from plain integer arithmetic
    function automatic logic [WIDTH+1:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        logic             b;
        logic             o;
        longint           sx;
        longint           sy;
        longint           sd;
        longint           lim;
        d   = x - y;
        b   = (x < y);
        sx  = $signed(x);
        sy  = $signed(y);
        sd  = sx - sy;
        lim = longint'(1) <<< (WIDTH - 1);
        o   = (sd >= lim) || (sd < -lim);
        return {b, o, d};
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 1;
            2:       return '1;
            3:       return {1'b1, {(WIDTH-1){1'b0}}};
            4:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // record what the pipeline accepted on each enabled edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_cnt = 0;
        end else if (en) begin
            if (edge_cnt < DEPTH) begin
                acc_q[edge_cnt] = in_valid;
                x_q[edge_cnt]   = X;
                y_q[edge_cnt]   = Y;
                exp_q[edge_cnt] = ref_sub(X, Y);
            end
            edge_cnt = edge_cnt + 1;
        end
    end

    // after k enabled edges the output shows the pair accepted on edge k-SLICES
    always @(negedge clk) begin
        logic             ev;
        logic [WIDTH+1:0] e;
        int               idx;
        if (reset) begin
            check_eq("reset_out_valid", 64'(out_valid), 64'(0));
            check_eq("reset_D", 64'(D), 64'(0));
            check_eq("reset_BORROW", 64'(BORROW), 64'(0));
            check_eq("reset_OVF", 64'(OVF), 64'(0));
        end else begin
            idx = edge_cnt - SLICES;
            ev  = (idx >= 0 && idx < DEPTH) ? acc_q[idx] : 1'b0;
            check_eq("out_valid", 64'(out_valid), 64'(ev));
            if (ev) begin
                e = exp_q[idx];
                check_eq("D", 64'(D), 64'(e[WIDTH-1:0]));
                check_eq("BORROW", 64'(BORROW), 64'(e[WIDTH+1]));
                check_eq("OVF", 64'(OVF), 64'(e[WIDTH]));
                $display("result %0d: 0x%08h - 0x%08h -> D=0x%08h B=%0b O=%0b",
                         idx, x_q[idx], y_q[idx], D, BORROW, OVF);
            end
        end
    end

    // single pair, then explicit check against hand-computed constants SLICES edges later
    task automatic send_directed(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic [WIDTH-1:0] dw, input logic bw, input logic ow);
        @(negedge clk);
        en = 1'b1; in_valid = 1'b1; X = x; Y = y;
        @(negedge clk);
        in_valid = 1'b0; X = WIDTH'($urandom); Y = WIDTH'($urandom);
        repeat (SLICES - 1) @(posedge clk);
        #1;
        check_eq("dir_out_valid", 64'(out_valid), 64'(1));
        check_eq("dir_D", 64'(D), 64'(dw));
        check_eq("dir_BORROW", 64'(BORROW), 64'(bw));
        check_eq("dir_OVF", 64'(OVF), 64'(ow));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; in_valid = 1'b0; X = '0; Y = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        send_directed(32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0);
        send_directed(32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send_directed(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        send_directed(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
        send_directed(32'h0001_0000, 32'd1, 32'h0000_FFFF, 1'b0, 1'b0);
        send_directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);

        // 8 back-to-back pairs
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en = 1'b1; in_valid = 1'b1; X = rand_op(); Y = rand_op();
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (SLICES + 2) @(negedge clk);

        // 6 pairs with a 3-cycle stall after the third; in_valid during stall must be ignored
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            en = !(i >= 3 && i < 6); in_valid = 1'b1; X = rand_op(); Y = rand_op();
        end
        @(negedge clk);
        en = 1'b1; in_valid = 1'b0;
        repeat (SLICES + 2) @(negedge clk);

        // random enable / valid traffic
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0); in_valid = $urandom_range(0, 1) == 1;
            X = rand_op(); Y = rand_op();
        end
        @(negedge clk);
        en = 1'b1; in_valid = 1'b0;
        repeat (SLICES + 2) @(negedge clk);

        // reset between edges with two pairs in flight
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; X = rand_op(); Y = rand_op();
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_eq("async_reset_out_valid", 64'(out_valid), 64'(0));
        check_eq("async_reset_D", 64'(D), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (SLICES + 3) @(negedge clk);
        send_directed(32'h1234_5678, 32'h1234_5679, 32'hFFFF_FFFF, 1'b1, 1'b0);
        repeat (SLICES + 2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sub_pipe.md
SUB_PIPE -- requirements
Module: sub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter SLICES, default 4, number of carry-pipelined slices; WIDTH % SLICES == 0, SLICES >= 1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  clock enable; 0 freezes all pipeline state.
REQ-006 SHALL have port in_valid  input  1  X/Y carry a new operand pair this cycle.
REQ-007 SHALL have port X  input  WIDTH  minuend, two's complement or unsigned.
REQ-008 SHALL have port Y  input  WIDTH  subtrahend.
REQ-009 SHALL have port D  output  WIDTH  registered difference X - Y mod 2^WIDTH.
REQ-010 SHALL have port BORROW  output  1  registered unsigned borrow, 1 when X < Y unsigned.
REQ-011 SHALL have port OVF  output  1  registered signed overflow of X - Y.
REQ-012 SHALL have port out_valid  output  1  D/BORROW/OVF hold the result of an accepted pair.

Function
REQ-013 SHALL compute D = X + ~Y + 1; slice 0 carry-in fixed at 1.
REQ-014 SHALL split operands into SLICES slices of S = WIDTH/SLICES bits; slice k uses bits [k*S +: S].
REQ-015 SHALL compute slice k in pipeline stage k, with carry-in from the stage k-1 carry register (slice 0: constant 1), so no combinational carry path spans more than S bits.
REQ-016 SHALL delay slice k of X and ~Y by k cycles before stage k (input skew) and delay the slice k sum by SLICES-1-k cycles after it (output deskew).
REQ-017 SHALL register all outputs; latency from acceptance (in_valid=1, en=1 at posedge) to out_valid=1 SHALL be exactly SLICES cycles.
REQ-018 SHALL accept one pair per enabled cycle, back-to-back, no bubbles inserted; results in input order.
REQ-019 SHALL propagate a valid bit through SLICES registers alongside the data; out_valid is the last one.
REQ-020 SHALL set BORROW = NOT(carry-out of top slice), aligned with D.
REQ-021 SHALL set OVF = (X[WIDTH-1] != Y[WIDTH-1]) AND (D[WIDTH-1] != X[WIDTH-1]), aligned with D.
REQ-022 SHALL, when en=0, hold every register (data, carries, valid, outputs) unchanged; in_valid ignored that cycle.
REQ-023 SHALL let data registers update freely when the valid bit is 0; outputs only meaningful with out_valid=1.
REQ-024 SHALL, for SLICES=1, degenerate to a single registered full-width subtractor, latency 1.
REQ-025 SHALL carry a borrow correctly through every slice boundary, incl. full-width ripple (e.g. 0 - 1).

Reset
REQ-026 SHALL, on reset=1, asynchronously clear all registers: D=0, BORROW=0, OVF=0, out_valid=0, all carry and valid registers 0.
REQ-027 SHALL discard pairs in flight at reset assertion; none emerge after release.
REQ-028 SHALL accept a new pair at the first posedge with reset=0 and en=1.
REQ-029 SHALL let reset override en.

Verification (WIDTH=32, SLICES=4, latency 4)
REQ-030 X=5, Y=3, in_valid=1 once -> 4 cycles later out_valid=1, D=0x00000002, BORROW=0, OVF=0.
REQ-031 X=0, Y=1 -> D=0xFFFFFFFF, BORROW=1, OVF=0 (borrow ripples through all 4 slices).
REQ-032 X=0x80000000, Y=1 -> D=0x7FFFFFFF, BORROW=0, OVF=1; X=0x7FFFFFFF, Y=0xFFFFFFFF -> D=0x80000000, BORROW=1, OVF=1.
REQ-033 8 back-to-back random pairs -> 8 consecutive out_valid cycles starting 4 cycles after first, each matching reference model in order.
REQ-034 Stream of 6 pairs with en=0 for 3 cycles mid-stream -> outputs frozen during stall, all 6 results correct, total latency per pair 4 enabled cycles.
REQ-035 Reset asserted between clock edges with 2 pairs in flight -> out_valid=0, D=0 immediately; no result appears afterwards; next pair after release emerges after 4 cycles.
